// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issue sequencer: ALU control codes, instruction
// opcodes, FSM state encoding and the opcode-to-control mapping.
package alu_sequencer_pkg;

  localparam int DATA_W_DEF = 48;

  localparam logic [0:3] CTL_AND = 4'h0;
  localparam logic [0:3] CTL_OR  = 4'h1;
  localparam logic [0:3] CTL_ADD = 4'h2;
  localparam logic [0:3] CTL_SUB = 4'h6;
  localparam logic [0:3] CTL_SLT = 4'h7;
  localparam logic [0:3] CTL_NOR = 4'hC;

  localparam logic [0:3] OP_AND = 4'd0;
  localparam logic [0:3] OP_OR  = 4'd1;
  localparam logic [0:3] OP_ADD = 4'd2;
  localparam logic [0:3] OP_SUB = 4'd3;
  localparam logic [0:3] OP_SLT = 4'd4;
  localparam logic [0:3] OP_NOR = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [0:3] ctl;
  } op_map_t;

  function automatic op_map_t map_opcode(input logic [0:3] op);
    op_map_t m;
    m.legal = 1'b1;
    m.ctl   = CTL_AND;
    case (op)
      OP_AND:  m.ctl = CTL_AND;
      OP_OR:   m.ctl = CTL_OR;
      OP_ADD:  m.ctl = CTL_ADD;
      OP_SUB:  m.ctl = CTL_SUB;
      OP_SLT:  m.ctl = CTL_SLT;
      OP_NOR:  m.ctl = CTL_NOR;
      default: m.legal = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREG x DATA_W, three combinational read ports, one synchronous
// write port, entry 0 hard-wired to zero.
module alu_regfile #(
  parameter int DATA_W = 48,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [0:2]        waddr_i,
  input  logic [0:DATA_W-1] wdata_i,
  input  logic [0:2]        ra1_i,
  output logic [0:DATA_W-1] rd1_o,
  input  logic [0:2]        ra2_i,
  output logic [0:DATA_W-1] rd2_o,
  input  logic [0:2]        ra3_i,
  output logic [0:DATA_W-1] rd3_o
);

  logic [0:DATA_W-1] regs_q [NREG];

  // NOTE: the whole array is cleared on reset because software-visible state must
  // read zero afterwards; that forces flops rather than a RAM macro, which is fine at 8 entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 3'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rd1_o = (ra1_i == 3'd0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 3'd0) ? '0 : regs_q[ra2_i];
  assign rd3_o = (ra3_i == 3'd0) ? '0 : regs_q[ra3_i];

endmodule

// File: rtl/alu_sequencer.sv
// Issue-side controller for the ALU: accepts register-to-register instructions,
// drives registered operands, waits out the ALU latency and writes the result back.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int NREG    = 8,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [0:15]       instr,
  input  logic              ld_valid,
  input  logic [0:2]        ld_addr,
  input  logic [0:DATA_W-1] ld_data,
  input  logic [0:2]        rd_addr,
  output logic [0:DATA_W-1] rd_data,
  output logic [0:DATA_W-1] alu_a,
  output logic [0:DATA_W-1] alu_b,
  output logic [0:3]        alu_control,
  input  logic [0:DATA_W-1] alu_result,
  input  logic              alu_zero,
  output logic              done,
  output logic              zero_flag,
  output logic              err,
  output logic              busy
);

  localparam int CNT_W = 3;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [0:2]        rd_q;
  logic [0:DATA_W-1] alu_a_q, alu_b_q;
  logic [0:3]        alu_ctl_q;
  logic              zero_q, done_q, err_q;

  op_map_t           op_map;
  logic              accept, issue;
  logic [0:DATA_W-1] rs_data, rt_data;
  logic              rf_we;
  logic [0:2]        rf_waddr;
  logic [0:DATA_W-1] rf_wdata;
  logic              unused_instr_bits;

  assign op_map            = map_opcode(instr[0:3]);
  assign accept            = (state_q == ST_IDLE) && instr_valid && instr_ready;
  assign issue             = accept && op_map.legal;
  assign unused_instr_bits = ^instr[13:15];

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (rf_we),
    .waddr_i (rf_waddr),
    .wdata_i (rf_wdata),
    .ra1_i   (instr[7:9]),
    .rd1_o   (rs_data),
    .ra2_i   (instr[10:12]),
    .rd2_o   (rt_data),
    .ra3_i   (rd_addr),
    .rd3_o   (rd_data)
  );

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (issue) state_d = ST_EXEC;
      ST_EXEC: if (cnt_q == CNT_W'(1)) state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Preload and writeback share the write port; the FSM state keeps them apart.
  always_comb begin
    instr_ready = (state_q == ST_IDLE) && !ld_valid;
    busy        = (state_q != ST_IDLE);
    rf_we       = 1'b0;
    rf_waddr    = ld_addr;
    rf_wdata    = ld_data;
    if (state_q == ST_WB) begin
      rf_we    = 1'b1;
      rf_waddr = rd_q;
      rf_wdata = alu_result;
    end else if (state_q == ST_IDLE && ld_valid) begin
      rf_we    = 1'b1;
    end
  end

  // Operands are captured at issue, so rs/rt aliasing rd sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rd_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_ctl_q <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= (state_q == ST_WB);
      err_q  <= accept && !op_map.legal;
      if (issue) begin
        rd_q      <= instr[4:6];
        alu_a_q   <= rs_data;
        alu_b_q   <= rt_data;
        alu_ctl_q <= op_map.ctl;
        cnt_q     <= CNT_W'(ALU_LAT);
      end else if (state_q == ST_EXEC) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_q == ST_WB) zero_q <= alu_zero;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctl_q;
  assign done        = done_q;
  assign err         = err_q;
  assign zero_flag   = zero_q;

endmodule
